// File: rtl/product_accumulator.sv
// Multiply-accumulate back end: sums N_TERMS products from the array multiplier
// into a saturating accumulator and holds the result until the consumer acknowledges it.
module product_accumulator #(
   parameter int PROD_W  = 8,
   parameter int ACC_W   = 16,
   parameter int N_TERMS = 8,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              start,
   input  logic [PROD_W-1:0] prod_in,
   input  logic              prod_valid,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic [CNT_W-1:0]  term_cnt,
   output logic              overflow,
   output logic              done,
   input  logic              out_ack,
   output logic [1:0]        fsm_state
);

   // Handshake: a product transfers on a rising edge where prod_valid and
   // prod_ready are both high; prod_ready is registered and high only in ACCUM.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);
   localparam logic [ACC_W-1:0] ACC_MAX   = '1;

   state_t           state;
   logic             accept;
   logic [ACC_W:0]   sum;

   assign accept    = prod_valid & prod_ready;
   assign fsm_state = state;

   // One extra bit of headroom makes the carry-out the saturation indicator.
   always_comb begin
      sum = {1'b0, acc_out} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         acc_out    <= '0;
         term_cnt   <= '0;
         overflow   <= 1'b0;
         done       <= 1'b0;
         prod_ready <= 1'b0;
      end else if (clear) begin
         state      <= S_IDLE;
         acc_out    <= '0;
         term_cnt   <= '0;
         overflow   <= 1'b0;
         done       <= 1'b0;
         prod_ready <= 1'b0;
      end else if (start) begin
         // Start acts identically from every state, and beats accept and out_ack.
         state      <= S_ACCUM;
         acc_out    <= '0;
         term_cnt   <= '0;
         overflow   <= 1'b0;
         done       <= 1'b0;
         prod_ready <= 1'b1;
      end else begin
         case (state)
            S_ACCUM: begin
               if (accept) begin
                  acc_out  <= sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
                  overflow <= overflow | sum[ACC_W];
                  term_cnt <= term_cnt + CNT_W'(1);
                  if (term_cnt == LAST_TERM) begin
                     state      <= S_DONE;
                     done       <= 1'b1;
                     prod_ready <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               if (out_ack) begin
                  state <= S_IDLE;
                  done  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: three instances (defaults, ACC_W=10, N_TERMS=1)
// share one stimulus stream; results are compared against values derived from plain arithmetic.
module tb_product_accumulator;

   logic       clk;
   logic       rst_n;
   logic       clear;
   logic       start;
   logic [7:0] prod_in;
   logic       prod_valid;
   logic       out_ack;

   logic        a_ready, a_ovf, a_done;
   logic [15:0] a_acc;
   logic [7:0]  a_cnt;
   logic [1:0]  a_state;

   logic        b_ready, b_ovf, b_done;
   logic [9:0]  b_acc;
   logic [7:0]  b_cnt;
   logic [1:0]  b_state;

   logic        c_ready, c_ovf, c_done;
   logic [15:0] c_acc;
   logic [7:0]  c_cnt;
   logic [1:0]  c_state;

   int n_checks = 0;
   int n_fail   = 0;

   product_accumulator dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
      .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(a_ready),
      .acc_out(a_acc), .term_cnt(a_cnt), .overflow(a_ovf), .done(a_done),
      .out_ack(out_ack), .fsm_state(a_state)
   );

   product_accumulator #(.ACC_W(10)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
      .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(b_ready),
      .acc_out(b_acc), .term_cnt(b_cnt), .overflow(b_ovf), .done(b_done),
      .out_ack(out_ack), .fsm_state(b_state)
   );

   product_accumulator #(.N_TERMS(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
      .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(c_ready),
      .acc_out(c_acc), .term_cnt(c_cnt), .overflow(c_ovf), .done(c_done),
      .out_ack(out_ack), .fsm_state(c_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0]  prod;
      int          gap;
      logic [15:0] exp_a;
      logic        exp_ovf_a;
      logic [9:0]  exp_b;
      logic        exp_ovf_b;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_state", a_state, 2'd1);
      chk("start_ready", a_ready, 1'b1);
      chk("start_acc", a_acc, 16'h0);
   endtask

   task automatic feed(input logic [7:0] v);
      prod_in    = v;
      prod_valid = 1'b1;
      chk("ready_before_accept", a_ready, 1'b1);
      step();
      prod_valid = 1'b0;
   endtask

   task automatic ack();
      out_ack = 1'b1;
      step();
      out_ack = 1'b0;
   endtask

   // Reference: saturating sum of the first n products against a ceiling.
   function automatic void ref_model(input int p[8], input int n, input int max_v,
                                     output int acc, output bit ovf);
      acc = 0;
      ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (acc + p[i] > max_v) begin
            acc = max_v;
            ovf = 1'b1;
         end else begin
            acc = acc + p[i];
         end
      end
   endfunction

   initial begin
      int exp_b;
      int prods[8];
      int accepted;
      int cycles;
      int ref_acc;
      bit ref_ovf;
      bit v;

      tbl[0] = '{8'hE1, 0, 16'h0708, 1'b0, 10'h3FF, 1'b1};
      tbl[1] = '{8'h01, 0, 16'h0008, 1'b0, 10'h008, 1'b0};
      tbl[2] = '{8'h09, 5, 16'h0048, 1'b0, 10'h048, 1'b0};
      tbl[3] = '{8'hFF, 0, 16'h07F8, 1'b0, 10'h3FF, 1'b1};
      tbl[4] = '{8'h7F, 3, 16'h03F8, 1'b0, 10'h3F8, 1'b0};
      tbl[5] = '{8'h80, 0, 16'h0400, 1'b0, 10'h3FF, 1'b1};
      tbl[6] = '{8'h00, 1, 16'h0000, 1'b0, 10'h000, 1'b0};

      rst_n = 1'b0; clear = 1'b0; start = 1'b0;
      prod_in = '0; prod_valid = 1'b0; out_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_acc", a_acc, 16'h0);
      chk("reset_cnt", a_cnt, 8'h0);
      chk("reset_ovf", a_ovf, 1'b0);
      chk("reset_done", a_done, 1'b0);
      chk("reset_ready", a_ready, 1'b0);
      chk("reset_state", a_state, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Table-driven full runs, optionally with a valid gap after four products.
      for (int r = 0; r < 7; r++) begin
         do_start();
         for (int k = 0; k < 8; k++) begin
            if (k == 4 && tbl[r].gap > 0) begin
               prod_valid = 1'b0;
               repeat (tbl[r].gap) begin
                  step();
                  chk("gap_ready", a_ready, 1'b1);
                  chk("gap_done", a_done, 1'b0);
               end
            end
            feed(tbl[r].prod);
            chk("done_timing", a_done, (k == 7));
         end
         chk("tbl_acc_a", a_acc, tbl[r].exp_a);
         chk("tbl_cnt_a", a_cnt, 8'd8);
         chk("tbl_ovf_a", a_ovf, tbl[r].exp_ovf_a);
         chk("tbl_acc_b", b_acc, tbl[r].exp_b);
         chk("tbl_ovf_b", b_ovf, tbl[r].exp_ovf_b);
         chk("tbl_done_b", b_done, 1'b1);
         chk("tbl_acc_c", c_acc, {8'h0, tbl[r].prod});
         chk("tbl_cnt_c", c_cnt, 8'd1);
         chk("tbl_done_c", c_done, 1'b1);
         chk("tbl_ready_c", c_ready, 1'b0);
         ack();
         chk("ack_done", a_done, 1'b0);
         chk("ack_state", a_state, 2'd0);
         chk("ack_acc_held", a_acc, tbl[r].exp_a);
         chk("ack_ready", a_ready, 1'b0);
      end

      // Saturation step by step on the narrow accumulator.
      do_start();
      for (int k = 1; k <= 8; k++) begin
         feed(8'hE1);
         exp_b = (225 * k > 1023) ? 1023 : 225 * k;
         chk("sat_acc_b", b_acc, exp_b);
         chk("sat_ovf_b", b_ovf, (225 * k > 1023));
      end
      chk("sat_done_b", b_done, 1'b1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clear_done_ovf_b", b_ovf, 1'b0);
      chk("clear_done_acc_b", b_acc, 10'h0);
      chk("clear_done_state", a_state, 2'd0);

      // clear beats start in ACCUM.
      do_start();
      feed(8'h10);
      feed(8'h10);
      clear = 1'b1; start = 1'b1; prod_valid = 1'b1; prod_in = 8'h33;
      step();
      clear = 1'b0; start = 1'b0; prod_valid = 1'b0;
      chk("prio_state", a_state, 2'd0);
      chk("prio_acc", a_acc, 16'h0);
      chk("prio_cnt", a_cnt, 8'h0);
      chk("prio_ready", a_ready, 1'b0);

      // start in ACCUM restarts and drops the product offered that cycle.
      do_start();
      for (int k = 0; k < 3; k++) feed(8'h10);
      chk("pre_restart_acc", a_acc, 16'h0030);
      start = 1'b1; prod_valid = 1'b1; prod_in = 8'h55;
      step();
      start = 1'b0; prod_valid = 1'b0;
      chk("restart_cnt", a_cnt, 8'h0);
      chk("restart_acc", a_acc, 16'h0);
      chk("restart_state", a_state, 2'd1);
      for (int k = 0; k < 8; k++) feed(8'h02);
      chk("restart_result", a_acc, 16'h0010);
      chk("restart_done", a_done, 1'b1);

      // start in DONE wins over out_ack.
      start = 1'b1; out_ack = 1'b1;
      step();
      start = 1'b0; out_ack = 1'b0;
      chk("done_start_state", a_state, 2'd1);
      chk("done_start_done", a_done, 1'b0);
      chk("done_start_acc", a_acc, 16'h0);

      // Products offered in DONE and IDLE are ignored.
      for (int k = 0; k < 8; k++) feed(8'hE1);
      prod_valid = 1'b1; prod_in = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("gate_done_acc", a_acc, 16'h0708);
         chk("gate_done_cnt", a_cnt, 8'd8);
         chk("gate_done_ready", a_ready, 1'b0);
      end
      prod_valid = 1'b0;
      ack();
      prod_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("gate_idle_acc", a_acc, 16'h0708);
         chk("gate_idle_cnt", a_cnt, 8'd8);
         chk("gate_idle_ready", a_ready, 1'b0);
      end
      prod_valid = 1'b0;

      // Asynchronous reset in the middle of a run.
      do_start();
      for (int k = 0; k < 3; k++) feed(8'h10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_acc", a_acc, 16'h0);
      chk("async_rst_cnt", a_cnt, 8'h0);
      chk("async_rst_ready", a_ready, 1'b0);
      chk("async_rst_done", a_done, 1'b0);
      chk("async_rst_ovf", a_ovf, 1'b0);
      chk("async_rst_state", a_state, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      do_start();
      for (int k = 0; k < 8; k++) feed(8'h01);
      chk("post_rst_acc", a_acc, 16'h0008);
      chk("post_rst_done", a_done, 1'b1);
      ack();

      // Randomized runs with random valid gaps.
      for (int run = 0; run < 16; run++) begin
         do_start();
         accepted = 0;
         cycles   = 0;
         while (accepted < 8 && cycles < 200) begin
            v          = 1'($urandom_range(0, 1));
            prod_in    = 8'($urandom_range(0, 255));
            prod_valid = v;
            if (v) prods[accepted] = int'(prod_in);
            step();
            cycles++;
            if (v) accepted++;
            chk("rnd_done_timing", a_done, (accepted == 8));
         end
         prod_valid = 1'b0;
         if (accepted < 8) chk("rnd_timeout", accepted, 8);
         ref_model(prods, accepted, 65535, ref_acc, ref_ovf);
         chk("rnd_acc_a", a_acc, ref_acc);
         chk("rnd_ovf_a", a_ovf, ref_ovf);
         chk("rnd_cnt_a", a_cnt, accepted);
         ref_model(prods, accepted, 1023, ref_acc, ref_ovf);
         chk("rnd_acc_b", b_acc, ref_acc);
         chk("rnd_ovf_b", b_ovf, ref_ovf);
         chk("rnd_acc_c", c_acc, prods[0]);
         chk("rnd_done_c", c_done, 1'b1);
         if ($urandom_range(0, 1) == 1) begin
            ack();
            chk("rnd_ack_state", a_state, 2'd0);
         end else begin
            clear = 1'b1;
            step();
            clear = 1'b0;
            chk("rnd_clear_acc", a_acc, 16'h0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
